// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - SPI frame command decoder sequencing register-bus reads/writes
//
// Decodes each SSEL frame as CMD, ADDR, DATA... and drives an 8-bit register bus
// with address auto-increment; supplies the next MISO byte to the SPI slave.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ssel_active           frame in progress (already synchronised)
//   rx_valid, rx_byte     received MOSI byte strobe and value
//   tx_byte, tx_valid     next MISO byte and its update strobe
//   bus_req, bus_we, bus_addr, bus_wdata   register-bus request (held until ack)
//   bus_ack, bus_rdata    register-bus completion strobe and read data
//   busy                  sequencer not idle
//   frame_err             sticky error for the current/last frame
module spi_cmd_sequencer #(
    parameter int          ADDR_W      = 8,
    parameter logic [7:0]  ID_BYTE     = 8'hA5,
    parameter int          BUS_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ssel_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic              bus_ack,
    input  logic [7:0]        bus_rdata,
    output logic              busy,
    output logic              frame_err
);

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_ID    = 8'h9F;
    localparam logic [7:0] TIMEOUT_BYTE = 8'hEE;
    localparam int         CNT_W     = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

    // WR_GAP/RD_GAP hold bus_req low for one cycle when a new byte arrives
    // together with the ack of the previous access.
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_WR_DATA, S_WR_BUS, S_WR_GAP,
        S_RD_BUS, S_RD_GAP, S_RD_DATA, S_ID, S_ERROR
    } state_t;

    state_t            state, state_n;
    logic              req_n, we_n, tx_valid_n, err_n, ssel_q;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        wdata_n, tx_n;
    logic [CNT_W-1:0]  cnt, cnt_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= 8'h00;
            tx_byte   <= 8'h00;
            tx_valid  <= 1'b0;
            frame_err <= 1'b0;
            cnt       <= '0;
            ssel_q    <= 1'b0;
        end else begin
            state     <= state_n;
            bus_req   <= req_n;
            bus_we    <= we_n;
            bus_addr  <= addr_n;
            bus_wdata <= wdata_n;
            tx_byte   <= tx_n;
            tx_valid  <= tx_valid_n;
            frame_err <= err_n;
            cnt       <= cnt_n;
            ssel_q    <= ssel_active;
        end
    end

    always_comb begin
        state_n    = state;
        req_n      = bus_req;
        we_n       = bus_we;
        addr_n     = bus_addr;
        wdata_n    = bus_wdata;
        tx_n       = tx_byte;
        tx_valid_n = 1'b0;
        err_n      = frame_err;
        cnt_n      = cnt;

        // Error is kept through deselect so it can be read back, and only
        // cleared when the next frame starts.
        if (ssel_active && !ssel_q) begin
            err_n = 1'b0;
        end

        if (!ssel_active) begin
            // Deselect overrides every other event, including a pending ack.
            state_n = S_IDLE;
            req_n   = 1'b0;
            tx_n    = 8'h00;
            cnt_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        case (rx_byte)
                            CMD_WRITE: begin
                                we_n    = 1'b1;
                                state_n = S_ADDR;
                            end
                            CMD_READ: begin
                                we_n    = 1'b0;
                                state_n = S_ADDR;
                            end
                            CMD_ID: begin
                                tx_n       = ID_BYTE;
                                tx_valid_n = 1'b1;
                                state_n    = S_ID;
                            end
                            default: begin
                                err_n   = 1'b1;
                                state_n = S_ERROR;
                            end
                        endcase
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        addr_n = rx_byte[ADDR_W-1:0];
                        if (bus_we) begin
                            state_n = S_WR_DATA;
                        end else begin
                            req_n   = 1'b1;
                            state_n = S_RD_BUS;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (rx_valid) begin
                        wdata_n = rx_byte;
                        req_n   = 1'b1;
                        state_n = S_WR_BUS;
                    end
                end
                S_RD_DATA: begin
                    // The previously fetched byte has been shifted out: prefetch next.
                    if (rx_valid) begin
                        req_n   = 1'b1;
                        state_n = S_RD_BUS;
                    end
                end
                S_WR_BUS, S_RD_BUS: begin
                    if (bus_ack) begin
                        req_n  = 1'b0;
                        cnt_n  = '0;
                        addr_n = bus_addr + ADDR_W'(1);
                        if (state == S_RD_BUS) begin
                            tx_n       = bus_rdata;
                            tx_valid_n = 1'b1;
                        end
                        if (rx_valid) begin
                            if (state == S_WR_BUS) begin
                                wdata_n = rx_byte;
                                state_n = S_WR_GAP;
                            end else begin
                                state_n = S_RD_GAP;
                            end
                        end else begin
                            state_n = (state == S_WR_BUS) ? S_WR_DATA : S_RD_DATA;
                        end
                    end else if (rx_valid) begin
                        // Byte arrived before the bus finished: overrun.
                        req_n   = 1'b0;
                        cnt_n   = '0;
                        err_n   = 1'b1;
                        state_n = S_ERROR;
                    end else if (cnt == CNT_LAST) begin
                        req_n      = 1'b0;
                        cnt_n      = '0;
                        tx_n       = TIMEOUT_BYTE;
                        tx_valid_n = 1'b1;
                        err_n      = 1'b1;
                        state_n    = S_ERROR;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_WR_GAP, S_RD_GAP: begin
                    if (rx_valid) begin
                        err_n   = 1'b1;
                        state_n = S_ERROR;
                    end else begin
                        req_n   = 1'b1;
                        state_n = (state == S_WR_GAP) ? S_WR_BUS : S_RD_BUS;
                    end
                end
                S_ID: begin
                    tx_n = ID_BYTE;
                end
                S_ERROR: begin
                    state_n = S_ERROR;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - scoreboard testbench for spi_cmd_sequencer
module tb_spi_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ssel_active = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       bus_req;
    logic       bus_we;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_ack = 1'b0;
    logic [7:0] bus_rdata = 8'h00;
    logic       busy;
    logic       frame_err;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       is_bus;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];

    spi_cmd_sequencer #(.ADDR_W(8), .ID_BYTE(8'hA5), .BUS_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .ssel_active(ssel_active),
        .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_byte(tx_byte), .tx_valid(tx_valid),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Monitor: every tx_valid pulse and every bus_req rising edge is checked
    // against the next expected event.
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_event: unexpected tx_byte=%02h, none expected", tx_byte);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.is_bus || tx_byte !== e.data) begin
                        n_err++;
                        $display("FAIL tx_event: got tx_byte=%02h, expected kind=%0d data=%02h",
                                 tx_byte, e.is_bus, e.data);
                    end
                end
            end
            if (bus_req && !req_prev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bus_event: unexpected req we=%0b addr=%02h", bus_we, bus_addr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (!e.is_bus || bus_we !== e.we || bus_addr !== e.addr ||
                        (e.we && bus_wdata !== e.data)) begin
                        n_err++;
                        $display("FAIL bus_event: got we=%0b addr=%02h wdata=%02h, expected kind=%0d we=%0b addr=%02h wdata=%02h",
                                 bus_we, bus_addr, bus_wdata, e.is_bus, e.we, e.addr, e.data);
                    end
                end
            end
            req_prev = bus_req;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_bus(input logic we, input logic [7:0] addr, input logic [7:0] data);
        exp_q.push_back('{is_bus: 1'b1, we: we, addr: addr, data: data});
    endtask

    task automatic push_tx(input logic [7:0] data);
        exp_q.push_back('{is_bus: 1'b0, we: 1'b0, addr: 8'h00, data: data});
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!bus_req && n < 20) begin
            tick();
            n++;
        end
        if (!bus_req) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: bus_req not seen within 20 cycles", name);
        end
    endtask

    task automatic ack(input logic [7:0] rdata);
        wait_req("ack_wait");
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        tick();
        bus_ack   = 1'b0;
    endtask

    task automatic ssel_on();
        ssel_active = 1'b1;
        tick();
    endtask

    task automatic ssel_off();
        ssel_active = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check("reset_outs", {tx_byte, bus_addr, bus_wdata, 8'h00}, 32'h0);
        check("reset_flags", {tx_valid, bus_req, bus_we, busy, frame_err}, 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: write frame 01,10,AB,CD
        ssel_on();
        send(8'h01);
        send(8'h10);
        push_bus(1'b1, 8'h10, 8'hAB);
        send(8'hAB);
        ack(8'h00);
        push_bus(1'b1, 8'h11, 8'hCD);
        send(8'hCD);
        ack(8'h00);
        check("wr_frame_err", frame_err, 0);
        check("wr_busy", busy, 1);
        ssel_off();
        check("wr_idle_busy", busy, 0);

        // 2: read frame 02,20 then deselect while a prefetch is outstanding
        ssel_on();
        send(8'h02);
        push_bus(1'b0, 8'h20, 8'h00);
        send(8'h20);
        push_tx(8'h5A);
        ack(8'h5A);
        push_bus(1'b0, 8'h21, 8'h00);
        send(8'hFF);
        push_tx(8'h6B);
        ack(8'h6B);
        check("rd_tx_6b", tx_byte, 8'h6B);
        push_bus(1'b0, 8'h22, 8'h00);
        send(8'hFF);
        check("rd_req_22", bus_req, 1);
        ssel_active = 1'b0;
        tick();
        check("desel_req", bus_req, 0);
        check("desel_busy", busy, 0);
        check("desel_tx", tx_byte, 8'h00);
        bus_ack   = 1'b1;
        bus_rdata = 8'h77;
        tick();
        bus_ack   = 1'b0;
        tick();
        check("late_ack_tx", tx_byte, 8'h00);

        // 3: ID frame, then invalid command frame
        ssel_on();
        push_tx(8'hA5);
        send(8'h9F);
        check("id_tx", tx_byte, 8'hA5);
        send(8'h12);
        check("id_hold", tx_byte, 8'hA5);
        ssel_off();
        ssel_on();
        send(8'h77);
        check("inv_err", frame_err, 1);
        send(8'h01);
        check("inv_busy", busy, 1);
        ssel_off();
        check("inv_err_held", frame_err, 1);
        ssel_on();
        check("err_cleared", frame_err, 0);
        ssel_off();

        // 4: write with ack withheld -> timeout after 15 cycles of req
        ssel_on();
        send(8'h01);
        send(8'h30);
        push_bus(1'b1, 8'h30, 8'h11);
        send(8'h11);
        push_tx(8'hEE);
        repeat (14) tick();
        check("to_req_still", bus_req, 1);
        tick();
        check("to_req_drop", bus_req, 0);
        check("to_tx", tx_byte, 8'hEE);
        check("to_err", frame_err, 1);
        send(8'h22);
        check("to_ignored_req", bus_req, 0);
        check("to_error_busy", busy, 1);
        ssel_off();

        // 5: address wrap FF -> 00
        ssel_on();
        send(8'h01);
        send(8'hFF);
        push_bus(1'b1, 8'hFF, 8'h01);
        send(8'h01);
        ack(8'h00);
        push_bus(1'b1, 8'h00, 8'h02);
        send(8'h02);
        ack(8'h00);
        check("wrap_err", frame_err, 0);
        ssel_off();

        // 6: ack and next byte in the same cycle during WR_BUS
        ssel_on();
        send(8'h01);
        send(8'h40);
        push_bus(1'b1, 8'h40, 8'hAA);
        send(8'hAA);
        wait_req("sim_wait");
        push_bus(1'b1, 8'h41, 8'hBB);
        bus_ack  = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'hBB;
        tick();
        bus_ack  = 1'b0;
        rx_valid = 1'b0;
        check("sim_gap_low", bus_req, 0);
        tick();
        check("sim_req_again", bus_req, 1);
        ack(8'h00);
        check("sim_err", frame_err, 0);
        ssel_off();

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
